// File: rtl/shift_sequencer_pkg.sv
// Shared types and helpers for the shift sequencer: FSM states, direction
// encodings and command-length normalisation.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // A zero or oversized length means "use the full register width".
    function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/response bundle between a parallel requester and the shift sequencer.
interface shift_sequencer_if #(
    parameter int WIDTH = 8
);
    localparam int LEN_W = $clog2(WIDTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_dir;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_data, cmd_len, cmd_dir, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, cmd_dir, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/shift_sequencer_divider.sv
// Bit-period timer: counts DIV cycles and pulses bit_strobe on the last one.
module bit_rate_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_strobe
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_strobe = !clear && (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || bit_strobe) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven serial shifter: transmits a parallel word bit by bit at a
// programmable rate while capturing serial_in into a receive word.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_sequencer_if.slave  bus,
    input  logic              abort,
    input  logic              serial_in,
    output logic              serial_out,
    output logic              bit_strobe,
    output logic              busy
);
    localparam int LEN_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             dir_q, dir_d;
    logic [LEN_W-1:0] len_n;
    logic [IDX_W-1:0] rx_idx;

    bit_rate_divider #(.DIV(DIV)) u_divider (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (state_q != SHIFT),
        .bit_strobe (bit_strobe)
    );

    assign len_n  = LEN_W'(norm_len(32'(bus.cmd_len), WIDTH));
    // Left shifts fill the word from its top, so the first sample lands at len-1.
    assign rx_idx = IDX_W'((dir_q == DIR_LEFT) ? (len_q - LEN_W'(1) - bit_cnt_q) : bit_cnt_q);

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = (state_q == DONE) ? rx_q : '0;
    assign busy          = (state_q != IDLE);
    assign serial_out    = (state_q == SHIFT) ? ((dir_q == DIR_LEFT) ? tx_q[WIDTH-1] : tx_q[0]) : 1'b0;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        len_d     = len_q;
        dir_d     = dir_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    len_d     = len_n;
                    dir_d     = bus.cmd_dir;
                    // Left-align the used field so its MSB sits at the output tap.
                    tx_d      = (bus.cmd_dir == DIR_LEFT) ? (bus.cmd_data << (WIDTH - 32'(len_n))) : bus.cmd_data;
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_strobe) begin
                    rx_d[rx_idx] = serial_in;
                    tx_d         = (dir_q == DIR_LEFT) ? (tx_q << 1) : (tx_q >> 1);
                    bit_cnt_d    = bit_cnt_q + LEN_W'(1);
                    if (bit_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            dir_q     <= DIR_RIGHT;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=8, DIV=2) with loopback and
// tied serial input, response back-pressure, abort and mid-shift reset.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int DIV   = 2;

    logic clk;
    logic reset_n;
    logic abort;
    logic serial_in;
    logic serial_out;
    logic bit_strobe;
    logic busy;
    logic loop_en;
    logic serial_fixed;

    int checks;
    int errors;

    shift_sequencer_if #(.WIDTH(WIDTH)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .abort      (abort),
        .serial_in  (serial_in),
        .serial_out (serial_out),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    assign serial_in = loop_en ? serial_out : serial_fixed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents a command at a falling edge; returns at the falling edge of cycle T+1.
    task automatic applyStimulus(input logic [7:0] data, input logic [3:0] len, input logic dir);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        bus.cmd_dir   = dir;
        checkOutput("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // seq[i] is the i-th transmitted bit; walks n bit periods then checks rsp_valid.
    task automatic checkBits(input logic [7:0] seq, input int n, input string tag);
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < DIV; c++) begin
                checkOutput({tag, "_serial_out"}, 32'(serial_out), 32'(seq[b]));
                checkOutput({tag, "_strobe"}, 32'(bit_strobe), (c == DIV - 1) ? 32'd1 : 32'd0);
                checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_rsp_valid_early"}, 32'(bus.rsp_valid), 32'd0);
                @(negedge clk);
            end
        end
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({tag, "_serial_out_done"}, 32'(serial_out), 32'd0);
    endtask

    task automatic finishResponse(input logic [7:0] exp_data, input string tag);
        checkOutput({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput({tag, "_rsp_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
        checkOutput({tag, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
        checkOutput({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        abort         = 1'b0;
        loop_en       = 1'b1;
        serial_fixed  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        bus.cmd_dir   = 1'b0;
        bus.rsp_ready = 1'b0;

        #12;
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_serial_out", 32'(serial_out), 32'd0);
        checkOutput("reset_strobe", 32'(bit_strobe), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] loopback 0x1D len 8 left");
        applyStimulus(8'h1D, 4'd8, 1'b1);
        checkBits(8'b1011_1000, 8, "left1d");
        // Back-pressure: response must hold, and a new command must be refused.
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h55;
        bus.cmd_len   = 4'd8;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_rsp_data", 32'(bus.rsp_data), 32'h1D);
            checkOutput("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        finishResponse(8'h1D, "left1d");

        $display("[TB] loopback 0x1D len 8 right");
        applyStimulus(8'h1D, 4'd8, 1'b0);
        checkBits(8'b0001_1101, 8, "right1d");
        finishResponse(8'h1D, "right1d");

        $display("[TB] 0xFD len 3 left, serial_in tied high");
        loop_en      = 1'b0;
        serial_fixed = 1'b1;
        applyStimulus(8'hFD, 4'd3, 1'b1);
        checkBits(8'b0000_0101, 3, "len3");
        finishResponse(8'h07, "len3");
        loop_en = 1'b1;

        $display("[TB] len 0 treated as full width");
        applyStimulus(8'h80, 4'd0, 1'b1);
        checkBits(8'b0000_0001, 8, "len0");
        finishResponse(8'h80, "len0");

        $display("[TB] abort while idle is ignored");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle_abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);

        $display("[TB] abort after third strobe");
        applyStimulus(8'hA5, 4'd8, 1'b1);
        for (int i = 0; i < 5; i++) @(negedge clk);
        checkOutput("abort_third_strobe", 32'(bit_strobe), 32'd1);
        checkOutput("abort_third_bit", 32'(serial_out), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_serial_out", 32'(serial_out), 32'd0);
        checkOutput("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            checkOutput("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end

        $display("[TB] reset in the middle of a shift");
        applyStimulus(8'hFF, 4'd8, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_serial_out", 32'(serial_out), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("midrst_strobe", 32'(bit_strobe), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'h3C, 4'd4, 1'b0);
        checkBits(8'b0000_1100, 4, "postrst");
        finishResponse(8'h0C, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller that sequences a bidirectional serial shift register: accepts a parallel word plus a bit count and direction, then shifts the bits out serially at a programmable bit rate. It captures serial_in into a receive word as it goes and returns that word on a response handshake. It sits between a parallel requester (CPU/bus side) and a serial link or a loopback path, and owns the shift register and bit-rate timing.

Parameters:
WIDTH, 8, maximum shift length in bits and width of the cmd/rsp data words (>=2)
DIV, 2, clock cycles per bit period (>=1); DIV=1 means one bit per clock
LEN_W, $clog2(WIDTH)+1, width of cmd_len (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_data  input  WIDTH  word to transmit; only bits [len-1:0] are used
cmd_len  input  LEN_W  number of bits to shift, 1..WIDTH; 0 is treated as WIDTH; values >WIDTH are clamped to WIDTH
cmd_dir  input  1  1 = left (MSB of the used field first); 0 = right (LSB first)
abort  input  1  synchronous cancel of the current operation
serial_out  output  1  current transmit bit
serial_in  input  1  receive bit, sampled on bit_strobe
bit_strobe  output  1  one-cycle pulse on the last cycle of each bit period (sample point)
busy  output  1  high in SHIFT and DONE
rsp_valid  output  1  received word available
rsp_ready  input  1  consumer accepts response
rsp_data  output  WIDTH  received word, right-aligned in [len-1:0], upper bits zero

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; cmd_ready=1; serial_out=0; bit_strobe=0; busy=0; rsp_valid=0; rsp_data=0; all counters 0. Release is synchronous to clk.
- States: IDLE, SHIFT, DONE.
- IDLE: cmd_ready=1, serial_out=0. A handshake (cmd_valid & cmd_ready) at edge T latches data, effective length and direction, loads the shift register and moves to SHIFT. From T+1: busy=1, cmd_ready=0, serial_out = first bit.
- Bit order: dir=1 transmits cmd_data[len-1] down to cmd_data[0]; dir=0 transmits cmd_data[0] up to cmd_data[len-1].
- Each bit is held on serial_out for exactly DIV cycles. bit_strobe is high on the last of those cycles, and serial_in is sampled on that cycle. The register shifts on that edge, and the next bit appears the following cycle.
- Receive mapping: the k-th sampled bit (k=0 first) goes to rsp_data[len-1-k] for dir=1 and to rsp_data[k] for dir=0. Bits [WIDTH-1:len] are 0.
- After the len-th strobe the state moves to DONE. rsp_valid=1 from cycle T+1+len*DIV, and rsp_data becomes valid at the same time. serial_out=0 in DONE.
- DONE: rsp_valid and rsp_data stay stable until rsp_ready. The handshake returns the state to IDLE, with rsp_valid=0 and cmd_ready=1 on the next cycle. There is no cmd/rsp bypass; minimum spacing between accepted commands is len*DIV+2 cycles.
- abort in SHIFT or DONE: next cycle state=IDLE, serial_out=0, rsp_valid=0, and no response is produced. abort in IDLE is ignored. abort has priority over a same-cycle strobe or rsp handshake.
- cmd_valid while busy: ignored (cmd_ready=0); the requester holds it.
- Reset mid-operation: immediate return to the reset values; the partial word is discarded.
- The bit counter and the divider counter both wrap to 0 at the start of each command.

Decomposition:
- Package shift_seq_pkg: state enum (IDLE/SHIFT/DONE), DIR_LEFT=1 and DIR_RIGHT=0 constants, a len-normalisation function (0 or >WIDTH -> WIDTH).
- One sub-module: bit_rate_divider (DIV-cycle counter with clear input, produces bit_strobe). The shift register and FSM stay in shift_sequencer.

Test Plan:
- WIDTH=8, DIV=2, loopback (serial_in=serial_out), cmd_data=8'h1D, len=8, dir=1 -> serial_out 0,0,0,1,1,1,0,1, each held 2 cycles; rsp_valid at T+17; rsp_data=8'h1D.
- Same with dir=0 -> serial_out 1,0,1,1,1,0,0,0; rsp_data=8'h1D.
- cmd_data=8'hFD, len=3, dir=1, serial_in tied 1 -> serial_out 1,0,1; 3 bit_strobe pulses; rsp_data=8'h07; rsp_valid at T+7.
- len=0 with cmd_data=8'h80, dir=1, loopback -> 8 bits sent, first bit 1; rsp_data=8'h80.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/rsp_data stable, cmd_ready=0. On handshake -> next cycle rsp_valid=0, cmd_ready=1.
- abort after the 3rd bit_strobe -> next cycle IDLE, busy=0, serial_out=0, no rsp_valid. Separately, drive reset_n low mid-SHIFT -> all outputs take reset values asynchronously; a new command after release completes correctly.
